// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding and digit-count helper for the keypad code builder
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int calc_digits(input int code_w, input int key_bits);
        return code_w / key_bits;
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// rtl/key_sync_edge.sv - 2-FF synchroniser plus delay stage, rising-edge strobe per raw key
module key_sync_edge #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [N-1:0] raw,
    output logic [N-1:0] strobe
);

    logic [N-1:0] sync1_q, sync1_d;
    logic [N-1:0] sync2_q, sync2_d;
    logic [N-1:0] dly_q,   dly_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
        end
    end

    // A held key strobes once; release never strobes.
    assign strobe = sync2_q & ~dly_q;

endmodule

// File: rtl/keypad_code_builder.sv
// rtl/keypad_code_builder.sv - builds fixed-width codes from key strobes and queues committed codes
module keypad_code_builder
    import keypad_pkg::*;
#(
    parameter int KEY_BITS = 1,
    parameter int CODE_W   = 9,
    parameter int DEPTH    = 4
) (
    input  logic                                               clk,
    input  logic                                               nrst,
    input  logic [2**KEY_BITS-1:0]                             keypad,
    input  logic                                               back_key,
    input  logic                                               clr_key,
    input  logic                                               commit_key,
    input  logic                                               arm,
    output logic [CODE_W-1:0]                                  partial,
    output logic [$clog2(calc_digits(CODE_W, KEY_BITS)+1)-1:0] digit_cnt,
    output logic [CODE_W-1:0]                                  out_code,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic                                               key_err,
    output logic                                               busy
);

    localparam int NK     = 2**KEY_BITS;
    localparam int DIGITS = calc_digits(CODE_W, KEY_BITS);
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int PTR_W  = $clog2(DEPTH);

    logic [NK+2:0]       strobe;
    logic [NK-1:0]       sym_stb;
    logic                back_stb, clr_stb, commit_stb;
    logic [KEY_BITS-1:0] sym_idx;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   partial_q, partial_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                key_err_q, key_err_d;
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CODE_W-1:0]   mem_q [DEPTH];
    logic                empty, full, pop, push, can_accept;

    key_sync_edge #(.N(NK + 3)) u_sync (
        .clk    (clk),
        .nrst   (nrst),
        .raw    ({commit_key, clr_key, back_key, keypad}),
        .strobe (strobe)
    );

    assign sym_stb    = strobe[NK-1:0];
    assign back_stb   = strobe[NK];
    assign clr_stb    = strobe[NK+1];
    assign commit_stb = strobe[NK+2];

    // Extra pointer bit distinguishes full from empty.
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = !empty && out_ready;
    assign can_accept = !full || pop;

    always_comb begin
        sym_idx = '0;
        for (int i = 0; i < NK; i++) begin
            if (sym_stb[i]) sym_idx = KEY_BITS'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        partial_d = partial_q;
        cnt_d     = cnt_q;
        key_err_d = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d   = ENTRY;
                    partial_d = '0;
                    cnt_d     = '0;
                end
            end
            ENTRY: begin
                if (!arm) begin
                    state_d   = IDLE;
                    partial_d = '0;
                    cnt_d     = '0;
                end else if (clr_stb) begin
                    partial_d = '0;
                    cnt_d     = '0;
                end else if (commit_stb) begin
                    if (cnt_q == '0) begin
                        key_err_d = 1'b1;
                    end else if (can_accept) begin
                        push      = 1'b1;
                        partial_d = '0;
                        cnt_d     = '0;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (back_stb) begin
                    if (cnt_q != '0) begin
                        partial_d = partial_q >> KEY_BITS;
                        cnt_d     = cnt_q - CNT_W'(1);
                    end
                end else if (sym_stb != '0) begin
                    if ($onehot(sym_stb) && (cnt_q < CNT_W'(DIGITS))) begin
                        partial_d = (partial_q << KEY_BITS) |
                                    {{(CODE_W-KEY_BITS){1'b0}}, sym_idx};
                        cnt_d     = cnt_q + CNT_W'(1);
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // arm is deliberately ignored until the stalled code is queued.
                if (can_accept) begin
                    push      = 1'b1;
                    partial_d = '0;
                    cnt_d     = '0;
                    state_d   = ENTRY;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            partial_q <= '0;
            cnt_q     <= '0;
            key_err_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
            key_err_q <= key_err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= partial_q;
    end

    assign partial   = partial_q;
    assign digit_cnt = cnt_q;
    assign out_code  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign out_valid = !empty;
    assign key_err   = key_err_q;
    assign busy      = (state_q == HOLD);

endmodule

// File: tb/tb_keypad_code_builder.sv
// tb/tb_keypad_code_builder.sv - directed self-checking bench for keypad_code_builder
module tb_keypad_code_builder;
    import keypad_pkg::*;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;

    logic [1:0] keypad_a = '0;
    logic       back_a = 0, clr_a = 0, commit_a = 0, arm_a = 0, out_ready_a = 0;
    logic [8:0] partial_a, out_code_a;
    logic [3:0] digit_cnt_a;
    logic       out_valid_a, key_err_a, busy_a;

    logic [3:0] keypad_b = '0;
    logic       back_b = 0, clr_b = 0, commit_b = 0, arm_b = 0, out_ready_b = 0;
    logic [7:0] partial_b, out_code_b;
    logic [2:0] digit_cnt_b;
    logic       out_valid_b, key_err_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int pop_cnt  = 0;
    int pop_sum  = 0;
    int valid_cycles = 0;
    int e0;

    always #5 clk = ~clk;

    keypad_code_builder #(.KEY_BITS(1), .CODE_W(9), .DEPTH(4)) dut_a (
        .clk(clk), .nrst(nrst), .keypad(keypad_a), .back_key(back_a), .clr_key(clr_a),
        .commit_key(commit_a), .arm(arm_a), .partial(partial_a), .digit_cnt(digit_cnt_a),
        .out_code(out_code_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .key_err(key_err_a), .busy(busy_a)
    );

    keypad_code_builder #(.KEY_BITS(2), .CODE_W(8), .DEPTH(4)) dut_b (
        .clk(clk), .nrst(nrst), .keypad(keypad_b), .back_key(back_b), .clr_key(clr_b),
        .commit_key(commit_b), .arm(arm_b), .partial(partial_b), .digit_cnt(digit_cnt_b),
        .out_code(out_code_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .key_err(key_err_b), .busy(busy_b)
    );

    always @(negedge clk) begin
        if (key_err_a) err_cnt++;
        if (out_valid_a) valid_cycles++;
        if (out_valid_a && out_ready_a) begin
            pop_cnt++;
            pop_sum += int'(out_code_a);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ctl bits are {commit, clr, back}
    task automatic press(input logic [1:0] ka, input logic [2:0] ca,
                         input logic [3:0] kb, input logic [2:0] cb);
        @(posedge clk); #1;
        keypad_a = ka; {commit_a, clr_a, back_a} = ca;
        keypad_b = kb; {commit_b, clr_b, back_b} = cb;
        repeat (2) @(posedge clk);
        #1;
        keypad_a = '0; {commit_a, clr_a, back_a} = '0;
        keypad_b = '0; {commit_b, clr_b, back_b} = '0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic sym_a(input int k);
        press(2'(1 << k), 3'b000, 4'b0000, 3'b000);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_partial",   32'(partial_a),   32'h0);
        chk("rst_digit_cnt", 32'(digit_cnt_a), 32'h0);
        chk("rst_out_valid", 32'(out_valid_a), 32'h0);
        chk("rst_key_err",   32'(key_err_a),   32'h0);
        chk("rst_busy",      32'(busy_a),      32'h0);
        nrst = 1'b1;
        arm_a = 1'b1;
        out_ready_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("armed_state", 32'(dut_a.state_q), 32'(ENTRY));

        // 1,0,1 then commit
        sym_a(1); sym_a(0); sym_a(1);
        chk("t1_partial", 32'(partial_a),   32'h005);
        chk("t1_cnt",     32'(digit_cnt_a), 32'd3);
        pop_cnt = 0; pop_sum = 0; valid_cycles = 0;
        press(2'b00, 3'b100, 4'b0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("t1_pops",     32'(pop_cnt),      32'd1);
        chk("t1_code",     32'(pop_sum),      32'd5);
        chk("t1_vcycles",  32'(valid_cycles), 32'd1);
        chk("t1_partial0", 32'(partial_a),    32'h0);

        // saturation and backspace
        e0 = err_cnt;
        for (int i = 0; i < 9; i++) sym_a(1);
        chk("t2_cnt9",   32'(digit_cnt_a), 32'd9);
        chk("t2_noerr",  32'(err_cnt),     32'(e0));
        sym_a(1);
        chk("t2_err",     32'(err_cnt),     32'(e0 + 1));
        chk("t2_partial", 32'(partial_a),   32'h1FF);
        chk("t2_cnt_sat", 32'(digit_cnt_a), 32'd9);
        press(2'b00, 3'b001, 4'b0, 3'b000);
        chk("t2_back_p", 32'(partial_a),   32'h0FF);
        chk("t2_back_c", 32'(digit_cnt_a), 32'd8);

        // FIFO fill and HOLD
        press(2'b00, 3'b010, 4'b0, 3'b000);
        chk("t3_clr", 32'(digit_cnt_a), 32'd0);
        out_ready_a = 1'b0;
        pop_cnt = 0; pop_sum = 0;
        for (int i = 0; i < 4; i++) begin
            sym_a(1);
            press(2'b00, 3'b100, 4'b0, 3'b000);
        end
        chk("t3_valid4", 32'(out_valid_a), 32'd1);
        chk("t3_busy4",  32'(busy_a),      32'd0);
        sym_a(1);
        press(2'b00, 3'b100, 4'b0, 3'b000);
        chk("t3_busy5",    32'(busy_a),      32'd1);
        chk("t3_hold_p",   32'(partial_a),   32'h001);
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        chk("t3_busy_off", 32'(busy_a),      32'd0);
        chk("t3_valid",    32'(out_valid_a), 32'd1);
        chk("t3_p0",       32'(partial_a),   32'h0);
        chk("t3_pop1",     32'(pop_cnt),     32'd1);
        out_ready_a = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t3_pops",  32'(pop_cnt), 32'd5);
        chk("t3_sum",   32'(pop_sum), 32'd5);
        chk("t3_empty", 32'(out_valid_a), 32'd0);

        // conflicting keys
        sym_a(1);
        e0 = err_cnt;
        press(2'b11, 3'b000, 4'b0, 3'b000);
        chk("t4_dual_err", 32'(err_cnt),     32'(e0 + 1));
        chk("t4_dual_p",   32'(partial_a),   32'h001);
        chk("t4_dual_c",   32'(digit_cnt_a), 32'd1);
        pop_cnt = 0;
        press(2'b00, 3'b110, 4'b0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_clr_win_p",  32'(partial_a), 32'h0);
        chk("t4_clr_win_po", 32'(pop_cnt),   32'd0);
        e0 = err_cnt;
        press(2'b00, 3'b100, 4'b0, 3'b000);
        chk("t4_empty_commit_err", 32'(err_cnt), 32'(e0 + 1));

        // KEY_BITS=2 instance
        arm_b = 1'b1;
        repeat (2) @(posedge clk);
        press(2'b00, 3'b000, 4'b1000, 3'b000);
        press(2'b00, 3'b000, 4'b0010, 3'b000);
        chk("t5_partial", 32'(partial_b), 32'h0D);
        press(2'b00, 3'b000, 4'b0000, 3'b100);
        chk("t5_valid", 32'(out_valid_b), 32'd1);
        chk("t5_code",  32'(out_code_b),  32'h0D);

        // async reset mid-entry
        out_ready_a = 1'b0;
        sym_a(1);
        press(2'b00, 3'b100, 4'b0, 3'b000);
        sym_a(1); sym_a(1); sym_a(0);
        chk("t6_pre_p", 32'(partial_a),   32'h006);
        chk("t6_pre_v", 32'(out_valid_a), 32'd1);
        @(posedge clk); #2;
        nrst = 1'b0;
        arm_a = 1'b0;
        arm_b = 1'b0;
        #1;
        chk("t6_rst_p",     32'(partial_a),     32'h0);
        chk("t6_rst_c",     32'(digit_cnt_a),   32'd0);
        chk("t6_rst_v",     32'(out_valid_a),   32'd0);
        chk("t6_rst_busy",  32'(busy_a),        32'd0);
        chk("t6_rst_state", 32'(dut_a.state_q), 32'(IDLE));
        chk("t6_rst_vb",    32'(out_valid_b),   32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        e0 = err_cnt;
        sym_a(1);
        chk("t6_idle_p",   32'(partial_a),     32'h0);
        chk("t6_idle_c",   32'(digit_cnt_a),   32'd0);
        chk("t6_idle_err", 32'(err_cnt),       32'(e0));
        chk("t6_idle_st",  32'(dut_a.state_q), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
